// File: rtl/telem_usb_streamer_if.sv
// FT245 user-side bus between the telemetry streamer (master) and the ft block (slave).
// Carries the TX word path toward the host and the RX word path from the host.
interface telem_usb_streamer_if #(
  parameter int BUS_WIDTH = 16
);
  logic [BUS_WIDTH-1:0]   ui_din;
  logic [BUS_WIDTH/8-1:0] ui_din_be;
  logic                   ui_din_valid;
  logic                   ui_din_full;
  logic [BUS_WIDTH-1:0]   ui_dout;
  logic [BUS_WIDTH/8-1:0] ui_dout_be;
  logic                   ui_dout_empty;
  logic                   ui_dout_get;

  modport master (
    output ui_din, ui_din_be, ui_din_valid, ui_dout_get,
    input  ui_din_full, ui_dout, ui_dout_be, ui_dout_empty
  );

  modport slave (
    input  ui_din, ui_din_be, ui_din_valid, ui_dout_get,
    output ui_din_full, ui_dout, ui_dout_be, ui_dout_empty
  );
endinterface

// File: rtl/telem_usb_streamer.sv
// Round-robin telemetry packet framer onto the FT245 TX bus, with a host echo mode.
// Each frame is SYNC_WORD, {seq, channel}, then the packet LS word first.
module telem_usb_streamer #(
  parameter int          CHANNELS     = 2,
  parameter int          PACKET_WIDTH = 88,
  parameter int          BUS_WIDTH    = 16,
  parameter logic [15:0] SYNC_WORD    = 16'hA55A
) (
  input  logic                             clk_128M,
  input  logic                             rst_128M,
  input  logic [1:0]                       mode,
  input  logic [CHANNELS*PACKET_WIDTH-1:0] pkt_data,
  input  logic [CHANNELS-1:0]              pkt_valid,
  telem_usb_streamer_if.master             ui,
  output logic [CHANNELS*16-1:0]           drop_count,
  output logic [31:0]                      frame_count
);

  localparam int WORDS = (PACKET_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int SR_W  = WORDS * BUS_WIDTH;
  localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int BEW   = BUS_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_HDR,
    S_PAYLOAD,
    S_LOOP
  } state_t;

  state_t                  state, state_nxt;
  logic [BUS_WIDTH-1:0]    din_r, din_nxt, hdr;
  logic [BEW-1:0]          be_r, be_nxt;
  logic                    valid_r, valid_nxt;
  logic [SR_W-1:0]         shreg, shreg_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [CW-1:0]           rr, rr_nxt, cur_ch, cur_ch_nxt, pick;
  logic [7:0]              seq, seq_nxt;
  logic [31:0]             frames_nxt;
  logic [CHANNELS-1:0]     pending, clr;
  logic [PACKET_WIDTH-1:0] hold [CHANNELS];
  logic [15:0]             drops [CHANNELS];
  logic                    found, accept, in_loop;
  int                      pick_j;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign accept  = valid_r && !ui.ui_din_full;
  assign in_loop = (state == S_LOOP);

  // Echo mode bypasses the registered stream outputs entirely.
  assign ui.ui_din       = in_loop ? ui.ui_dout : din_r;
  assign ui.ui_din_be    = in_loop ? ui.ui_dout_be : be_r;
  assign ui.ui_din_valid = in_loop ? !ui.ui_dout_empty : valid_r;
  assign ui.ui_dout_get  = !rst_128M && !ui.ui_dout_empty && (!in_loop || !ui.ui_din_full);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_drop
    assign drop_count[g*16 +: 16] = drops[g];
  end

  always_comb begin
    found  = 1'b0;
    pick   = rr;
    pick_j = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      pick_j = int'(rr) + k;
      if (pick_j >= CHANNELS) pick_j = pick_j - CHANNELS;
      if (!found && pending[CW'(pick_j)]) begin
        found = 1'b1;
        pick  = CW'(pick_j);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    din_nxt    = din_r;
    be_nxt     = be_r;
    valid_nxt  = valid_r;
    shreg_nxt  = shreg;
    idx_nxt    = idx;
    rr_nxt     = rr;
    cur_ch_nxt = cur_ch;
    seq_nxt    = seq;
    frames_nxt = frame_count;
    clr        = '0;
    hdr        = '0;
    hdr[15:0]  = {seq, 8'(cur_ch)};
    case (state)
      S_IDLE: begin
        valid_nxt = 1'b0;
        if (mode == 2'd0) begin
          state_nxt = S_LOOP;
        end else if (mode == 2'd1 && found) begin
          clr[pick]  = 1'b1;
          cur_ch_nxt = pick;
          shreg_nxt  = SR_W'(hold[pick]);
          rr_nxt     = (pick == CW'(CHANNELS - 1)) ? '0 : pick + 1'b1;
          din_nxt    = BUS_WIDTH'(SYNC_WORD);
          be_nxt     = '1;
          valid_nxt  = 1'b1;
          state_nxt  = S_SYNC;
        end
      end
      S_SYNC: begin
        if (accept) begin
          din_nxt   = hdr;
          state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        if (accept) begin
          din_nxt   = shreg[BUS_WIDTH-1:0];
          shreg_nxt = shreg >> BUS_WIDTH;
          idx_nxt   = '0;
          state_nxt = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (accept) begin
          if (idx == IW'(WORDS - 1)) begin
            valid_nxt  = 1'b0;
            frames_nxt = frame_count + 32'd1;
            seq_nxt    = seq + 8'd1;
            state_nxt  = S_IDLE;
          end else begin
            din_nxt   = shreg[BUS_WIDTH-1:0];
            shreg_nxt = shreg >> BUS_WIDTH;
            idx_nxt   = idx + 1'b1;
          end
        end
      end
      S_LOOP: begin
        valid_nxt = 1'b0;
        if (mode != 2'd0) state_nxt = S_IDLE;
      end
      default: begin
        valid_nxt = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Frame control and registered stream outputs
  always_ff @(posedge clk_128M or posedge rst_128M) begin
    if (rst_128M) begin
      state       <= S_IDLE;
      din_r       <= '0;
      be_r        <= '0;
      valid_r     <= 1'b0;
      idx         <= '0;
      rr          <= '0;
      cur_ch      <= '0;
      seq         <= '0;
      frame_count <= '0;
    end else begin
      state       <= state_nxt;
      din_r       <= din_nxt;
      be_r        <= be_nxt;
      valid_r     <= valid_nxt;
      idx         <= idx_nxt;
      rr          <= rr_nxt;
      cur_ch      <= cur_ch_nxt;
      seq         <= seq_nxt;
      frame_count <= frames_nxt;
    end
  end

  always_ff @(posedge clk_128M) begin
    shreg <= shreg_nxt;
  end

  // Capture: a pending slot freed by this cycle's frame start accepts the new packet
  always_ff @(posedge clk_128M or posedge rst_128M) begin
    if (rst_128M) begin
      pending <= '0;
      for (int c = 0; c < CHANNELS; c++) drops[c] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (mode != 2'd1) begin
          pending[c] <= 1'b0;
        end else if (pkt_valid[c] && (!pending[c] || clr[c])) begin
          pending[c] <= 1'b1;
        end else begin
          if (pkt_valid[c]) drops[c] <= sat_inc16(drops[c]);
          if (clr[c]) pending[c] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_128M) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (mode == 2'd1 && pkt_valid[c] && (!pending[c] || clr[c]))
        hold[c] <= pkt_data[c*PACKET_WIDTH +: PACKET_WIDTH];
    end
  end

endmodule
